// File: rtl/alu_addr_seq_pkg.sv
// Shared ALU operation codes and addressing-mode encodings for the alu and its sequencers.
package alu_addr_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SR  = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SL  = 3'b101;

    localparam logic [1:0] MODE_ABS = 2'b00;
    localparam logic [1:0] MODE_ZP  = 2'b01;
    localparam logic [1:0] MODE_REL = 2'b10;

endpackage

// File: rtl/alu_addr_seq.sv
// Effective-address sequencer: drives the shared 8-bit alu add over LO/HI cycles to form 16-bit addresses.
// Latency: done two edges after accepted start for ZP, three for ABS/REL.
// Backpressure: start is only accepted in IDLE; requests in LO/HI/DONE are ignored.
module alu_addr_seq
    import alu_addr_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] base,
    input  logic [7:0]  index,
    output logic [2:0]  alu_control,
    output logic [7:0]  alu_AI,
    output logic [7:0]  alu_BI,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_Y,
    input  logic        alu_carry_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic        page_cross
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } seq_state_t;

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [1:0]  mode_q;
    logic [15:0] base_q;
    logic [7:0]  index_q;
    logic        c_lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LO;
            ST_LO:   state_nxt = (mode_q == MODE_ZP) ? ST_DONE : ST_HI;
            ST_HI:   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU inputs come only from state and latched operands, never from start.
    always_comb begin
        alu_control  = ALU_ADD;
        alu_AI       = 8'h00;
        alu_BI       = 8'h00;
        alu_carry_in = 1'b0;
        case (state)
            ST_LO: begin
                alu_AI = base_q[7:0];
                alu_BI = index_q;
            end
            ST_HI: begin
                alu_AI       = base_q[15:8];
                alu_BI       = (mode_q == MODE_REL && index_q[7]) ? 8'hFF : 8'h00;
                alu_carry_in = c_lo;
            end
            default: ;
        endcase
    end

    assign busy = (state == ST_LO) || (state == ST_HI);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q     <= MODE_ABS;
            base_q     <= 16'h0000;
            index_q    <= 8'h00;
            c_lo       <= 1'b0;
            ea         <= 16'h0000;
            page_cross <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        base_q  <= base;
                        index_q <= index;
                    end
                end
                ST_LO: begin
                    ea[7:0] <= alu_Y;
                    c_lo    <= alu_carry_out;
                    if (mode_q == MODE_ZP) begin
                        ea[15:8]   <= 8'h00;
                        page_cross <= 1'b0;
                    end
                end
                ST_HI: begin
                    // A changed high byte means either a carry or a borrow crossed the page.
                    ea[15:8]   <= alu_Y;
                    page_cross <= (alu_Y != base_q[15:8]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_addr_seq.sv
// Bench for alu_addr_seq: combinational alu stand-in, arithmetic reference model and directed vectors.
module tb_alu_addr_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] base;
    logic [7:0]  index;
    logic [2:0]  alu_control;
    logic [7:0]  alu_AI;
    logic [7:0]  alu_BI;
    logic        alu_carry_in;
    logic [7:0]  alu_Y;
    logic        alu_carry_out;
    logic        busy;
    logic        done;
    logic [15:0] ea;
    logic        page_cross;

    int n_checks = 0;
    int n_fail   = 0;

    alu_addr_seq dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode), .base(base), .index(index),
        .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI), .alu_carry_in(alu_carry_in),
        .alu_Y(alu_Y), .alu_carry_out(alu_carry_out),
        .busy(busy), .done(done), .ea(ea), .page_cross(page_cross)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared alu: only ADD produces a result.
    always_comb begin
        logic [8:0] sum;
        sum = 9'h000;
        if (alu_control == 3'b000)
            sum = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'h00, alu_carry_in};
        {alu_carry_out, alu_Y} = sum;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation = accept, n_busy busy cycles, one done cycle.
    bit          m_active = 0;
    int          m_t = 0;
    int          m_n = 0;
    logic [1:0]  m_mode;
    logic [15:0] m_base;
    logic [7:0]  m_idx;
    logic [15:0] m_res_ea;
    logic        m_res_pc;
    logic [15:0] m_ea = 16'h0000;
    logic        m_pc = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active = 0;
            m_ea     = 16'h0000;
            m_pc     = 1'b0;
        end else if (m_active) begin
            m_t++;
            if (m_t == m_n) begin
                m_ea = m_res_ea;
                m_pc = m_res_pc;
            end
            if (m_t > m_n) m_active = 0;
        end else if (start) begin
            m_active = 1;
            m_t      = 0;
            m_mode   = mode;
            m_base   = base;
            m_idx    = index;
            if (mode == 2'b01) begin
                m_n      = 1;
                m_res_ea = {8'h00, 8'(base[7:0] + index)};
                m_res_pc = 1'b0;
            end else begin
                m_n = 2;
                if (mode == 2'b10) m_res_ea = base + {{8{index[7]}}, index};
                else               m_res_ea = base + {8'h00, index};
                m_res_pc = (m_res_ea[15:8] != base[15:8]);
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            logic [7:0] e_ai, e_bi;
            logic       e_ci;
            logic [8:0] lo_sum;
            e_ai = 8'h00; e_bi = 8'h00; e_ci = 1'b0;
            lo_sum = {1'b0, m_base[7:0]} + {1'b0, m_idx};
            if (m_active && m_t == 0) begin
                e_ai = m_base[7:0];
                e_bi = m_idx;
            end else if (m_active && m_t == 1 && m_n == 2) begin
                e_ai = m_base[15:8];
                e_bi = (m_mode == 2'b10 && m_idx[7]) ? 8'hFF : 8'h00;
                e_ci = lo_sum[8];
            end
            chk("cyc_busy", busy, m_active && m_t < m_n);
            chk("cyc_done", done, m_active && m_t == m_n);
            chk("cyc_alu_control", alu_control, 3'b000);
            chk("cyc_alu_AI", alu_AI, e_ai);
            chk("cyc_alu_BI", alu_BI, e_bi);
            chk("cyc_alu_carry_in", alu_carry_in, e_ci);
            if (!m_active || m_t == 0 || m_t == m_n) begin
                chk("cyc_ea", ea, m_ea);
                chk("cyc_page_cross", page_cross, m_pc);
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] m, input logic [15:0] b,
                          input logic [7:0] i, input logic [15:0] exp_ea, input logic exp_pc,
                          input int exp_lat, input int exp_busy);
        int  edges;
        int  busyc;
        bit  seen;
        start = 1'b1; mode = m; base = b; index = i;
        @(posedge clk); #1;
        start = 1'b0; base = 16'hDEAD; index = 8'h77; mode = 2'b01;
        edges = 0; seen = 0;
        busyc = busy ? 1 : 0;
        while (!seen && edges < 8) begin
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1;
            else if (busy) busyc++;
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_ea"}, ea, exp_ea);
        chk({name, "_page_cross"}, page_cross, exp_pc);
        chk({name, "_busy_cycles"}, busyc, exp_busy);
        @(posedge clk); #1;
        edges++;
        chk({name, "_done_width"}, done, 0);
        chk({name, "_latency"}, edges, exp_lat);
        chk({name, "_ea_held"}, ea, exp_ea);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; mode = 2'b00; base = 16'h0000; index = 8'h00;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ea", ea, 16'h0000);
        chk("rst_page_cross", page_cross, 0);
        chk("rst_alu_AI", alu_AI, 8'h00);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        run_op("abs_cross",   2'b00, 16'h12F0, 8'h20, 16'h1310, 1'b1, 3, 2);
        run_op("abs_nocross", 2'b00, 16'h1200, 8'h05, 16'h1205, 1'b0, 3, 2);
        run_op("zp_wrap",     2'b01, 16'hABF0, 8'h20, 16'h0010, 1'b0, 2, 1);
        run_op("rel_neg",     2'b10, 16'h0300, 8'hFE, 16'h02FE, 1'b1, 3, 2);
        run_op("rel_wrap",    2'b10, 16'hFFF0, 8'h20, 16'h0010, 1'b1, 3, 2);
        run_op("mode3_abs",   2'b11, 16'h12F0, 8'h20, 16'h1310, 1'b1, 3, 2);
        run_op("rel_pos",     2'b10, 16'h0410, 8'h7F, 16'h048F, 1'b0, 3, 2);

        // start held high through LO/HI/DONE with different operands
        start = 1'b1; mode = 2'b00; base = 16'h1200; index = 8'h05;
        @(posedge clk); #1;
        base = 16'h5555; index = 8'h01;
        @(posedge clk); #1;
        chk("hold_hi_busy", busy, 1);
        @(posedge clk); #1;
        chk("hold_done", done, 1);
        chk("hold_first_ea", ea, 16'h1205);
        @(posedge clk); #1;
        chk("hold_ignored_in_done", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_accept_in_idle", busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_second_done", done, 1);
        chk("hold_second_ea", ea, 16'h5556);
        @(posedge clk); #1;

        // asynchronous reset during HI
        start = 1'b1; mode = 2'b00; base = 16'h12F0; index = 8'h20;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_in_hi", busy, 1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ea", ea, 16'h0000);
        chk("mid_rst_page_cross", page_cross, 0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("mid_no_done", done, 0);
        end
        run_op("after_rst", 2'b00, 16'h12F0, 8'h20, 16'h1310, 1'b1, 3, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
